// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared stage indices and default widths for the hazard unit
package hazard_scoreboard_pkg;
  typedef enum int {FS, DS, IS, ES, MS, WS} stage_e;
  localparam int NSTAGE_DEF = int'(WS) + 1;
  localparam int NREG_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int NSRC_DEF = 3;
  localparam int CNT_W_DEF = 3;
  localparam int SRC_W_DEF = NSRC_DEF * REG_AW_DEF;
endpackage

// File: rtl/hazard_reg_scoreboard.sv
// hazard_reg_scoreboard: per-register latency counters with multi-port RAW lookup
module hazard_reg_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int NSRC = NSRC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NSRC-1:0]              src_en,
  input  logic [NSRC-1:0][REG_AW-1:0]  src,
  input  logic                         wr,
  input  logic [REG_AW-1:0]            dest,
  input  logic [CNT_W-1:0]             lat,
  input  logic                         adv,
  input  logic                         clr,
  output logic                         raw
);
  logic [CNT_W-1:0] cnt [NREG];
  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    for (int r = 1; r < NREG; r++)
      cnt[r] <= (reset || clr) ? '0 :
                (wr && dest == REG_AW'(r)) ? lat :
                (adv && cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
  end
  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < NSRC; k++)
      raw = raw | (src_en[k] && src[k] != '0 && cnt[src[k]] != '0);
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/flush generation from RAW, long-op, store-load and redirect/exception events
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int IS_IDX = int'(IS),
  parameter int ES_IDX = int'(ES),
  parameter int NREG = NREG_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int NSRC = NSRC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_valid,
  input  logic [NSRC-1:0]          is_src_en,
  input  logic [NSRC*REG_AW-1:0]   is_src,
  input  logic                     is_dest_en,
  input  logic [REG_AW-1:0]        is_dest,
  input  logic [CNT_W-1:0]         is_lat,
  input  logic                     is_long,
  input  logic                     long_done,
  input  logic                     es_ld_valid,
  input  logic                     ms_st_valid,
  input  logic                     bp_redirect,
  input  logic                     exc_flush,
  output logic [NSTAGE-1:0]        stall,
  output logic [NSTAGE-1:0]        flush,
  output logic                     is_issue,
  output logic [31:0]              stall_cycles
);
  logic long_busy, long_op, stld, raw_hit, hold_es, raw_stall, redir, live;
  assign long_op = long_busy & ~long_done;
  assign stld = es_ld_valid & ms_st_valid;
  assign live = ~reset & ~exc_flush;
  assign hold_es = live & (long_op | stld);
  assign raw_stall = live & ~hold_es & is_valid & raw_hit;
  assign redir = live & bp_redirect;
  always_comb begin
    stall = '0;
    flush = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      flush[i] = ~live | (hold_es && i == ES_IDX + 1) | (raw_stall && i == ES_IDX) | (redir && i >= 1 && i < IS_IDX);
      stall[i] = ((hold_es && i <= ES_IDX) || (raw_stall && i <= IS_IDX)) && !flush[i];
    end
  end
  assign is_issue = is_valid & ~stall[IS_IDX] & ~flush[IS_IDX];
  hazard_reg_scoreboard #(.NREG(NREG), .REG_AW(REG_AW), .NSRC(NSRC), .CNT_W(CNT_W)) u_sb (
    .clk(clk),
    .reset(reset),
    .src_en(is_src_en),
    .src(is_src),
    .wr(is_issue & is_dest_en),
    .dest(is_dest),
    .lat(is_lat),
    .adv(~exc_flush & ~long_op & ~stld),
    .clr(exc_flush),
    .raw(raw_hit)
  );
  always_ff @(posedge clk) begin
    long_busy <= (reset || exc_flush) ? 1'b0 : (is_issue && is_long) ? 1'b1 : long_done ? 1'b0 : long_busy;
    stall_cycles <= reset ? '0 : (stall[IS_IDX] && stall_cycles != '1) ? stall_cycles + 32'd1 : stall_cycles;
  end
endmodule
